pwm_duty_sequencer: RTL and testbench
=====================================

PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 SHALL have parameter PWM_WIDTH, default 10, giving the duty/period/step resolution in bits.
REQ-002 SHALL have parameter PERIOD_INIT, default 10'h3FF, giving the period_value after reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en_req  input  1  level request to run the PWM.
REQ-006 SHALL have port cfg_valid  input  1  config offer.
REQ-007 SHALL have port cfg_ready  output  1  config acceptance; combinational from state and en_req only.
REQ-008 SHALL have port cfg_duty  input  PWM_WIDTH  target duty.
REQ-009 SHALL have port cfg_period  input  PWM_WIDTH  target period.
REQ-010 SHALL have port cfg_step  input  PWM_WIDTH  ramp step per period.
REQ-011 SHALL have port period_complete  input  1  one-cycle pulse from the downstream PWM stage.
REQ-012 SHALL have port duty_cycle  output  PWM_WIDTH  registered duty to the PWM stage.
REQ-013 SHALL have port period_value  output  PWM_WIDTH  registered period to the PWM stage.
REQ-014 SHALL have port pwm_enable  output  1  registered enable to the PWM stage.
REQ-015 SHALL have port ramp_busy  output  1  high in RAMP or STOP.
REQ-016 SHALL have port at_target  output  1  high in HOLD.

Function
REQ-017 SHALL implement states IDLE, RAMP, HOLD and STOP.
REQ-018 SHALL drive cfg_ready = (IDLE) or (HOLD and en_req); cfg_ready SHALL be 0 in RAMP and STOP.
REQ-019 SHALL complete a transfer on cfg_valid and cfg_ready at a clock edge, latching:
- target = min(cfg_duty, cfg_period)
- shadow_period = cfg_period
- step = max(cfg_step, 1)
REQ-020 SHALL, on a transfer in IDLE, copy shadow_period to period_value on the same edge.
REQ-021 SHALL, on a transfer in HOLD, move to RAMP and copy shadow_period to period_value at the first following period_complete.
REQ-022 SHALL, in IDLE with en_req=1, set pwm_enable=1 next cycle and enter RAMP, with duty_cycle starting from 0; a same-cycle config transfer SHALL also be applied.
REQ-023 SHALL update duty_cycle in RAMP/STOP only on a period_complete cycle, with the new value visible the next cycle; duty_cycle SHALL NOT change on any other cycle.
REQ-024 SHALL, in RAMP on period_complete, update duty_cycle as follows:
- |target - duty| <= step: duty_cycle <= target and enter HOLD
- otherwise: duty_cycle moves by step toward target
REQ-025 SHALL compute the ramp in PWM_WIDTH+1 bits; duty_cycle never wraps and never passes target.
REQ-026 SHALL enter STOP from RAMP or HOLD when en_req=0; in STOP the effective target is 0 and the ramp-down uses the same step.
REQ-027 SHALL, when duty_cycle reaches 0 at a period_complete in STOP, set pwm_enable=0 next cycle and enter IDLE; en_req returning to 1 during STOP SHALL NOT abort the stop.
REQ-028 SHALL treat RAMP with target equal to the current duty as done at the next period_complete (enter HOLD).
REQ-029 SHALL ignore period_complete in IDLE and HOLD.

Reset
REQ-030 SHALL, when rst=0 at a clock edge, set:
- state = IDLE
- duty_cycle = 0, target = 0
- period_value = shadow_period = PERIOD_INIT
- step = 1
- pwm_enable = 0
This SHALL apply from any state, mid-ramp included.
REQ-031 SHALL have no state element without a reset value.

Structure
REQ-032 SHALL place the state encoding and PWM_WIDTH default in a shared package pwm_pkg, used also by the PWM stage.
REQ-033 SHALL contain one sub-module, pwm_ramp_step: a combinational saturating step toward target that returns a done flag.

Verification
REQ-034 SHALL test: reset; cfg (duty 100, period 500, step 30) in IDLE; en_req=1 -> duty 0,30,60,90,100 on successive period_complete pulses, then at_target=1.
REQ-035 SHALL test: cfg duty 600, period 400 -> target clamped to 400.
REQ-036 SHALL test: cfg_step 0 -> ramp advances by 1 per period.
REQ-037 SHALL test: in HOLD at duty 100, en_req=0 with step 40 -> duty 60,20,0; pwm_enable=0 one cycle after the last pulse; state IDLE.
REQ-038 SHALL test: in HOLD, new cfg period 200 -> period_value unchanged until the next period_complete, then 200; cfg_ready=0 throughout RAMP.
REQ-039 SHALL test: rst=0 mid-RAMP -> all outputs at reset values next cycle; period_complete pulses during IDLE leave duty_cycle unchanged.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sequencer and the downstream PWM stage.
package pwm_pkg;

  localparam int PWM_WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// One saturating step of duty toward target; done flags that target was reached.
module pwm_ramp_step
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next_duty,
  output logic             done
);

  logic [WIDTH:0] duty_x;
  logic [WIDTH:0] target_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] moved;

  assign duty_x   = {1'b0, duty};
  assign target_x = {1'b0, target};
  assign step_x   = {1'b0, step};

  // The extra bit keeps duty+step from wrapping; overshoot is caught by the diff test.
  always_comb begin
    diff      = '0;
    moved     = '0;
    next_duty = duty;
    done      = 1'b0;
    if (target_x >= duty_x) begin
      diff  = target_x - duty_x;
      moved = duty_x + step_x;
    end else begin
      diff  = duty_x - target_x;
      moved = duty_x - step_x;
    end
    if (diff <= step_x) begin
      next_duty = target;
      done      = 1'b1;
    end else begin
      next_duty = moved[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps the PWM duty toward a configured target one step per PWM period,
// and ramps it back to zero before shutting the PWM stage off.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int                   PWM_WIDTH   = PWM_WIDTH_DEFAULT,
  parameter logic [PWM_WIDTH-1:0] PERIOD_INIT = 10'h3FF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_req,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  input  logic [PWM_WIDTH-1:0] cfg_period,
  input  logic [PWM_WIDTH-1:0] cfg_step,
  input  logic                 period_complete,
  output logic [PWM_WIDTH-1:0] duty_cycle,
  output logic [PWM_WIDTH-1:0] period_value,
  output logic                 pwm_enable,
  output logic                 ramp_busy,
  output logic                 at_target
);

  pwm_state_t           state;
  logic [PWM_WIDTH-1:0] target;
  logic [PWM_WIDTH-1:0] shadow_period;
  logic [PWM_WIDTH-1:0] step;
  logic                 period_pending;

  logic                 xfer;
  logic [PWM_WIDTH-1:0] cfg_target;
  logic [PWM_WIDTH-1:0] cfg_step_eff;
  logic [PWM_WIDTH-1:0] ramp_target;
  logic [PWM_WIDTH-1:0] next_duty;
  logic                 step_done;

  assign cfg_ready    = (state == ST_IDLE) || ((state == ST_HOLD) && en_req);
  assign xfer         = cfg_valid && cfg_ready;
  assign cfg_target   = (cfg_duty < cfg_period) ? cfg_duty : cfg_period;
  assign cfg_step_eff = (cfg_step == '0) ? PWM_WIDTH'(1) : cfg_step;
  assign ramp_target  = (state == ST_STOP) ? '0 : target;
  assign ramp_busy    = (state == ST_RAMP) || (state == ST_STOP);
  assign at_target    = (state == ST_HOLD);

  pwm_ramp_step #(
    .WIDTH(PWM_WIDTH)
  ) u_ramp_step (
    .duty     (duty_cycle),
    .target   (ramp_target),
    .step     (step),
    .next_duty(next_duty),
    .done     (step_done)
  );

  // A config accepted in HOLD only reaches period_value at a period boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      duty_cycle     <= '0;
      target         <= '0;
      period_value   <= PERIOD_INIT;
      shadow_period  <= PERIOD_INIT;
      step           <= PWM_WIDTH'(1);
      pwm_enable     <= 1'b0;
      period_pending <= 1'b0;
    end else begin
      if (xfer) begin
        target        <= cfg_target;
        shadow_period <= cfg_period;
        step          <= cfg_step_eff;
      end
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            period_value   <= cfg_period;
            period_pending <= 1'b0;
          end
          if (en_req) begin
            state      <= ST_RAMP;
            duty_cycle <= '0;
            pwm_enable <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (period_complete) begin
            duty_cycle <= next_duty;
            if (period_pending) begin
              period_value   <= shadow_period;
              period_pending <= 1'b0;
            end
          end
          if (!en_req) begin
            state <= ST_STOP;
          end else if (period_complete && step_done) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!en_req) begin
            state <= ST_STOP;
          end else if (xfer) begin
            state          <= ST_RAMP;
            period_pending <= 1'b1;
          end
        end
        ST_STOP: begin
          if (period_complete) begin
            duty_cycle <= next_duty;
            if (period_pending) begin
              period_value   <= shadow_period;
              period_pending <= 1'b0;
            end
            if (step_done) begin
              state      <= ST_IDLE;
              pwm_enable <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with hand-computed duty/period sequences.
module tb_pwm_duty_sequencer;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic         en_req;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_duty;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_step;
  logic         period_complete;
  logic [W-1:0] duty_cycle;
  logic [W-1:0] period_value;
  logic         pwm_enable;
  logic         ramp_busy;
  logic         at_target;

  int total = 0;
  int bad   = 0;

  pwm_duty_sequencer #(
    .PWM_WIDTH  (W),
    .PERIOD_INIT(10'h3FF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_req         (en_req),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_duty       (cfg_duty),
    .cfg_period     (cfg_period),
    .cfg_step       (cfg_step),
    .period_complete(period_complete),
    .duty_cycle     (duty_cycle),
    .period_value   (period_value),
    .pwm_enable     (pwm_enable),
    .ramp_busy      (ramp_busy),
    .at_target      (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d", tag, actual, expected);
    end
  endtask

  // Offers one config for a single cycle.
  task automatic applyStimulus(input int duty, input int period, input int stp);
    cfg_duty   = W'(duty);
    cfg_period = W'(period);
    cfg_step   = W'(stp);
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic pulsePeriod();
    period_complete = 1'b1;
    tick();
    period_complete = 1'b0;
  endtask

  initial begin
    int up_seq[4]   = '{30, 60, 90, 100};
    int down_seq[3] = '{60, 20, 0};
    int clamp_seq[4] = '{100, 200, 300, 400};

    rst = 1'b0; en_req = 1'b0; cfg_valid = 1'b0; period_complete = 1'b0;
    cfg_duty = '0; cfg_period = '0; cfg_step = '0;
    tick(); tick();
    rst = 1'b1;
    checkOutput("rst_duty", duty_cycle, 0);
    checkOutput("rst_period", period_value, 10'h3FF);
    checkOutput("rst_enable", pwm_enable, 0);
    checkOutput("rst_busy", ramp_busy, 0);
    checkOutput("rst_at_target", at_target, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);

    // Config in IDLE takes effect on period_value immediately.
    applyStimulus(100, 500, 30);
    checkOutput("idle_cfg_period", period_value, 500);
    checkOutput("idle_cfg_enable", pwm_enable, 0);

    en_req = 1'b1;
    tick();
    checkOutput("start_enable", pwm_enable, 1);
    checkOutput("start_duty", duty_cycle, 0);
    checkOutput("start_busy", ramp_busy, 1);
    checkOutput("ramp_cfg_ready", cfg_ready, 0);
    foreach (up_seq[i]) begin
      pulsePeriod();
      checkOutput($sformatf("up_duty%0d", i), duty_cycle, up_seq[i]);
      tick();
      checkOutput($sformatf("up_hold%0d", i), duty_cycle, up_seq[i]);
    end
    checkOutput("up_at_target", at_target, 1);
    checkOutput("up_busy", ramp_busy, 0);
    checkOutput("hold_cfg_ready", cfg_ready, 1);

    // New period in HOLD is deferred until the next period boundary.
    applyStimulus(100, 200, 40);
    checkOutput("shadow_period_wait0", period_value, 500);
    checkOutput("shadow_cfg_ready0", cfg_ready, 0);
    checkOutput("shadow_busy", ramp_busy, 1);
    tick();
    checkOutput("shadow_period_wait1", period_value, 500);
    checkOutput("shadow_cfg_ready1", cfg_ready, 0);
    pulsePeriod();
    checkOutput("shadow_period_new", period_value, 200);
    checkOutput("shadow_duty", duty_cycle, 100);
    checkOutput("shadow_at_target", at_target, 1);

    // Ramp down at step 40; en_req coming back mid-stop must not abort.
    en_req = 1'b0;
    tick();
    checkOutput("stop_busy", ramp_busy, 1);
    checkOutput("stop_enable", pwm_enable, 1);
    checkOutput("stop_cfg_ready", cfg_ready, 0);
    foreach (down_seq[i]) begin
      pulsePeriod();
      checkOutput($sformatf("down_duty%0d", i), duty_cycle, down_seq[i]);
      if (i == 0) en_req = 1'b1;
    end
    checkOutput("stop_done_enable", pwm_enable, 0);
    checkOutput("stop_done_busy", ramp_busy, 0);
    checkOutput("stop_done_at_target", at_target, 0);
    checkOutput("stop_done_cfg_ready", cfg_ready, 1);
    en_req = 1'b0;
    tick();

    // Duty above period is clamped; same-cycle enable applies the config too.
    en_req = 1'b1;
    applyStimulus(600, 400, 100);
    checkOutput("clamp_period", period_value, 400);
    checkOutput("clamp_enable", pwm_enable, 1);
    checkOutput("clamp_start_duty", duty_cycle, 0);
    foreach (clamp_seq[i]) begin
      pulsePeriod();
      checkOutput($sformatf("clamp_duty%0d", i), duty_cycle, clamp_seq[i]);
    end
    checkOutput("clamp_at_target", at_target, 1);
    pulsePeriod();
    checkOutput("clamp_hold_duty", duty_cycle, 400);

    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Zero step behaves as step 1.
    applyStimulus(5, 50, 0);
    checkOutput("step0_period", period_value, 50);
    for (int i = 1; i <= 3; i++) begin
      pulsePeriod();
      checkOutput($sformatf("step0_duty%0d", i), duty_cycle, i);
    end
    checkOutput("step0_busy", ramp_busy, 1);

    // Reset mid-ramp.
    rst = 1'b0;
    tick();
    checkOutput("midrst_duty", duty_cycle, 0);
    checkOutput("midrst_period", period_value, 10'h3FF);
    checkOutput("midrst_enable", pwm_enable, 0);
    checkOutput("midrst_busy", ramp_busy, 0);
    checkOutput("midrst_at_target", at_target, 0);
    rst = 1'b1;
    en_req = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      pulsePeriod();
      checkOutput($sformatf("idle_pulse_duty%0d", i), duty_cycle, 0);
      checkOutput($sformatf("idle_pulse_busy%0d", i), ramp_busy, 0);
    end

    // Target equal to current duty finishes at the first period boundary.
    en_req = 1'b1;
    tick();
    checkOutput("eq_busy", ramp_busy, 1);
    pulsePeriod();
    checkOutput("eq_at_target", at_target, 1);
    checkOutput("eq_duty", duty_cycle, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
